// File: rtl/control_unit.sv
// control_unit: execute-side partner of cpu_core. Runs register/ALU
// instructions on a 4 x 8-bit register file with {C,Z} flags and drives the
// core's sequencing inputs (end_inst, jmp_inst, jmp_address, inst_condition,
// hlt_inst).
//
// Sequencing contract with the core: every sequencing output is a pure
// combinational function of ir, clks, flags and the execute qualifier
// (state == EXEC_STATE). The core samples them on the rising edge that ends
// the current step; end_inst=1 tells it the instruction retires on that edge.
// Outside execute they are all 0, except hlt_inst, which stays 1 while halted.
module control_unit #(
  parameter logic [1:0] EXEC_STATE = 2'd1,
  parameter int         STEPS      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic [STEPS-1:0] clks,
  input  logic [1:0]       state,
  output logic             inst_condition,
  output logic             end_inst,
  output logic             jmp_inst,
  output logic [7:0]       jmp_address,
  output logic             hlt_inst,
  output logic [1:0]       flags,
  output logic             illegal_op,
  input  logic [1:0]       dbg_sel,
  output logic [7:0]       dbg_data
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_MOVI = 8'h01;
  localparam logic [7:0] OP_MOV  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_AND  = 8'h05;
  localparam logic [7:0] OP_XOR  = 8'h06;
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_JZ   = 8'h11;
  localparam logic [7:0] OP_JC   = 8'h12;
  localparam logic [7:0] OP_HLT  = 8'hFF;

  // PH_OPS: operands latched at T0, waiting for the T1 write-back.
  // PH_HALT: sticky until reset; blocks every architectural write.
  typedef enum logic [1:0] {PH_IDLE, PH_OPS, PH_HALT} phase_t;

  phase_t      phase_q, phase_d;
  logic [7:0]  rf [4];
  logic [1:0]  flags_q, flags_d;   // {C,Z}
  logic        ill_q;
  logic [7:0]  opa_q, opb_q, alu_op_q;
  logic [1:0]  dst_q;

  logic        ex, t0, t1, late, halted;
  logic [7:0]  opcode, imm8;
  logic [1:0]  ra, rb;
  logic        is_alu;

  logic        rf_we, flags_we, op_ld, ill_set;
  logic [1:0]  rf_wa;
  logic [7:0]  rf_wd;
  logic [7:0]  alu_res;
  logic        alu_c;
  logic [8:0]  sum9;
  logic        unused_ir;

  assign ex     = (state == EXEC_STATE);
  // Step decode gives T0 priority so a malformed multi-hot bus cannot fire
  // two steps' worth of actions at once.
  assign t0     = clks[0];
  assign t1     = clks[1] & ~clks[0];
  assign late   = ~clks[0] & ~clks[1] & (|clks[STEPS-1:2]);
  assign halted = (phase_q == PH_HALT);

  assign opcode = ir[31:24];
  assign ra     = ir[17:16];
  assign rb     = ir[9:8];
  assign imm8   = ir[15:8];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_XOR);
  assign unused_ir = ^ir[23:18];

  assign flags      = flags_q;
  assign illegal_op = ill_q;
  assign dbg_data   = rf[dbg_sel];

  // ALU on the operands latched at T0 (so A==B reads the pre-write value).
  always_comb begin
    sum9    = {1'b0, opa_q} + {1'b0, opb_q};
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (alu_op_q)
      OP_ADD: begin alu_res = sum9[7:0];     alu_c = sum9[8];         end
      OP_SUB: begin alu_res = opa_q - opb_q; alu_c = (opa_q < opb_q); end
      OP_AND: alu_res = opa_q & opb_q;
      OP_XOR: alu_res = opa_q ^ opb_q;
      default: ;
    endcase
  end

  // Sequencing outputs to the core.
  always_comb begin
    inst_condition = 1'b0;
    end_inst       = 1'b0;
    jmp_inst       = 1'b0;
    jmp_address    = 8'h00;
    if (ex) begin
      inst_condition = 1'b1;
      jmp_address    = ir[7:0];
      if (t0) begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_HLT: end_inst = 1'b0;
          OP_JMP: begin jmp_inst = 1'b1; end_inst = 1'b1; end
          OP_JZ:  begin inst_condition = flags_q[0]; jmp_inst = flags_q[0]; end_inst = 1'b1; end
          OP_JC:  begin inst_condition = flags_q[1]; jmp_inst = flags_q[1]; end_inst = 1'b1; end
          default: end_inst = 1'b1;
        endcase
      end else if (t1 || late) begin
        end_inst = 1'b1;
      end
    end
    hlt_inst = halted || (ex && t0 && (opcode == OP_HLT));
  end

  // Phase next-state and write enables.
  always_comb begin
    phase_d  = phase_q;
    rf_we    = 1'b0;
    rf_wa    = ra;
    rf_wd    = 8'h00;
    flags_we = 1'b0;
    flags_d  = flags_q;
    op_ld    = 1'b0;
    ill_set  = 1'b0;
    if (!halted && ex) begin
      if (t0) begin
        phase_d = PH_IDLE;
        case (opcode)
          OP_MOVI: begin rf_we = 1'b1; rf_wd = imm8;   end
          OP_MOV:  begin rf_we = 1'b1; rf_wd = rf[rb]; end
          OP_ADD, OP_SUB, OP_AND, OP_XOR: begin op_ld = 1'b1; phase_d = PH_OPS; end
          OP_HLT:  phase_d = PH_HALT;
          OP_NOP, OP_JMP, OP_JZ, OP_JC: ;
          default: ill_set = 1'b1;
        endcase
      end else if (t1) begin
        phase_d = PH_IDLE;
        if (phase_q == PH_OPS && is_alu) begin
          rf_we    = 1'b1;
          rf_wa    = dst_q;
          rf_wd    = alu_res;
          flags_we = 1'b1;
          flags_d  = {alu_c, (alu_res == 8'h00)};
        end
      end else if (late) begin
        phase_d = PH_IDLE;
      end
    end
  end

  // State, register file, flags and operand latch; reset discards everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_IDLE;
      flags_q  <= 2'b00;
      ill_q    <= 1'b0;
      opa_q    <= 8'h00;
      opb_q    <= 8'h00;
      alu_op_q <= 8'h00;
      dst_q    <= 2'd0;
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else begin
      phase_q <= phase_d;
      if (rf_we)    rf[rf_wa] <= rf_wd;
      if (flags_we) flags_q   <= flags_d;
      if (ill_set)  ill_q     <= 1'b1;
      if (op_ld) begin
        opa_q    <= rf[ra];
        opb_q    <= rf[rb];
        alu_op_q <= opcode;
        dst_q    <= ra;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed instruction sequences with
// hand-computed expectations pushed into a queue, checked at the falling edge.
module tb_control_unit;

  localparam logic [1:0]  EX  = 2'd1;
  localparam logic [15:0] T0  = 16'h0001;
  localparam logic [15:0] T1  = 16'h0002;

  localparam logic [3:0] K_COND = 4'd0, K_END = 4'd1, K_JMP = 4'd2, K_JADDR = 4'd3;
  localparam logic [3:0] K_HLT = 4'd4, K_FLAGS = 4'd5, K_ILL = 4'd6, K_DBG = 4'd7;

  logic        clk, reset;
  logic [31:0] ir;
  logic [15:0] clks;
  logic [1:0]  state;
  logic        inst_condition, end_inst, jmp_inst, hlt_inst, illegal_op;
  logic [7:0]  jmp_address, dbg_data;
  logic [1:0]  flags, dbg_sel;

  logic [11:0] exp_q[$];   // {kind, expected value}
  int          n_cmp, n_fail;

  control_unit #(.EXEC_STATE(2'd1), .STEPS(16)) dut (
    .clk(clk), .reset(reset), .ir(ir), .clks(clks), .state(state),
    .inst_condition(inst_condition), .end_inst(end_inst), .jmp_inst(jmp_inst),
    .jmp_address(jmp_address), .hlt_inst(hlt_inst), .flags(flags),
    .illegal_op(illegal_op), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [1:0] a,
                                     input logic [7:0] imm, input logic [7:0] tgt);
    return {op, 6'd0, a, imm, tgt};
  endfunction

  function automatic string kname(input logic [3:0] k);
    case (k)
      K_COND: return "inst_condition";
      K_END:  return "end_inst";
      K_JMP:  return "jmp_inst";
      K_JADDR: return "jmp_address";
      K_HLT:  return "hlt_inst";
      K_FLAGS: return "flags";
      K_ILL:  return "illegal_op";
      default: return "dbg_data";
    endcase
  endfunction

  // Driver tasks
  task automatic drv(input logic [1:0] st, input logic [15:0] ck, input logic [31:0] instr);
    state = st; clks = ck; ir = instr;
  endtask

  task automatic idle();
    drv(2'd0, 16'h0000, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_v(input logic [3:0] k, input logic [7:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic expect_seq(input logic c, input logic e, input logic j,
                            input logic [7:0] ja, input logic h);
    expect_v(K_COND, {7'd0, c});
    expect_v(K_END, {7'd0, e});
    expect_v(K_JMP, {7'd0, j});
    expect_v(K_JADDR, ja);
    expect_v(K_HLT, {7'd0, h});
  endtask

  task automatic exec1(input logic [31:0] instr);
    drv(EX, T0, instr); tick(); idle();
  endtask

  task automatic alu2(input logic [31:0] instr);
    drv(EX, T0, instr); expect_v(K_END, 8'd0); tick();
    drv(EX, T1, instr); expect_v(K_END, 8'd1); tick();
    idle();
  endtask

  task automatic chk_reg(input logic [1:0] sel, input logic [7:0] v);
    idle(); dbg_sel = sel; expect_v(K_DBG, v); tick();
  endtask

  task automatic chk_flags(input logic [1:0] v);
    idle(); expect_v(K_FLAGS, {6'd0, v}); tick();
  endtask

  // Scoreboard monitor: pops every expectation queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      logic [11:0] e;
      logic [7:0]  act;
      e = exp_q.pop_front();
      case (e[11:8])
        K_COND:  act = {7'd0, inst_condition};
        K_END:   act = {7'd0, end_inst};
        K_JMP:   act = {7'd0, jmp_inst};
        K_JADDR: act = jmp_address;
        K_HLT:   act = {7'd0, hlt_inst};
        K_FLAGS: act = {6'd0, flags};
        K_ILL:   act = {7'd0, illegal_op};
        default: act = dbg_data;
      endcase
      n_cmp++;
      if (act !== e[7:0]) begin
        n_fail++;
        $display("FAIL %s @%0t: got 0x%02h expected 0x%02h", kname(e[11:8]), $time, act, e[7:0]);
      end
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; dbg_sel = 2'd0; idle();
    tick(); tick();
    // reset state
    expect_v(K_HLT, 8'd0); expect_v(K_FLAGS, 8'd0); expect_v(K_ILL, 8'd0);
    expect_v(K_END, 8'd0); expect_v(K_DBG, 8'd0);
    tick();
    reset = 1'b0;

    // MOVI R0,0x2A
    drv(EX, T0, mk(8'h01, 2'd0, 8'h2A, 8'h11)); expect_seq(1, 1, 0, 8'h11, 0); tick();
    chk_reg(2'd0, 8'h2A); chk_flags(2'b00);

    // ADD with carry out
    exec1(mk(8'h01, 2'd0, 8'hF0, 8'h00));
    exec1(mk(8'h01, 2'd1, 8'h20, 8'h00));
    alu2(mk(8'h03, 2'd0, 8'h01, 8'h00));
    chk_reg(2'd0, 8'h10); chk_reg(2'd1, 8'h20); chk_flags(2'b10);

    // SUB to zero, then JZ taken / JC not taken
    exec1(mk(8'h01, 2'd2, 8'h05, 8'h00));
    exec1(mk(8'h01, 2'd3, 8'h05, 8'h00));
    alu2(mk(8'h04, 2'd2, 8'h03, 8'h00));
    chk_reg(2'd2, 8'h00); chk_flags(2'b01);
    drv(EX, T0, mk(8'h11, 2'd0, 8'h00, 8'h40)); expect_seq(1, 1, 1, 8'h40, 0); tick();
    drv(EX, T0, mk(8'h12, 2'd0, 8'h00, 8'h41)); expect_seq(0, 1, 0, 8'h41, 0); tick();

    // XOR -> Z=0, JZ not taken
    alu2(mk(8'h06, 2'd0, 8'h01, 8'h00));
    chk_reg(2'd0, 8'h30); chk_flags(2'b00);
    drv(EX, T0, mk(8'h11, 2'd0, 8'h00, 8'h40)); expect_seq(0, 1, 0, 8'h40, 0); tick();

    // SUB with borrow, JC taken
    alu2(mk(8'h04, 2'd1, 8'h00, 8'h00));
    chk_reg(2'd1, 8'hF0); chk_flags(2'b10);
    drv(EX, T0, mk(8'h12, 2'd0, 8'h00, 8'h55)); expect_seq(1, 1, 1, 8'h55, 0); tick();

    // ADD R1,R1 doubles; AND clears carry
    alu2(mk(8'h03, 2'd1, 8'h01, 8'h00));
    chk_reg(2'd1, 8'hE0); chk_flags(2'b10);
    alu2(mk(8'h05, 2'd0, 8'h01, 8'h00));
    chk_reg(2'd0, 8'h20); chk_flags(2'b00);

    // MOV R3,R0
    drv(EX, T0, mk(8'h02, 2'd3, 8'h00, 8'h22)); expect_seq(1, 1, 0, 8'h22, 0); tick();
    chk_reg(2'd3, 8'h20);

    // Not in execute: everything quiet, no write
    drv(2'd2, T0, mk(8'h01, 2'd0, 8'h77, 8'h33)); expect_seq(0, 0, 0, 8'h00, 0); tick();
    drv(2'd0, T0, mk(8'h10, 2'd0, 8'h00, 8'h80)); expect_seq(0, 0, 0, 8'h00, 0); tick();
    chk_reg(2'd0, 8'h20);

    // JMP
    drv(EX, T0, mk(8'h10, 2'd0, 8'h00, 8'h80)); expect_seq(1, 1, 1, 8'h80, 0); tick();

    // Step beyond T1: recovery end, no write; all-zero step: no action
    drv(EX, 16'h0020, mk(8'h01, 2'd0, 8'h77, 8'h00)); expect_v(K_END, 8'd1); tick();
    drv(EX, 16'h0000, mk(8'h10, 2'd0, 8'h00, 8'h80));
    expect_v(K_END, 8'd0); expect_v(K_JMP, 8'd0); tick();
    chk_reg(2'd0, 8'h20);

    // Illegal opcode: sticky flag from next cycle
    drv(EX, T0, mk(8'h7E, 2'd0, 8'h00, 8'h00));
    expect_v(K_END, 8'd1); expect_v(K_ILL, 8'd0); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); expect_v(K_ILL, 8'd1); tick();
    end

    // HLT: held, writes blocked
    drv(EX, T0, mk(8'hFF, 2'd0, 8'h00, 8'h00)); expect_v(K_HLT, 8'd1); tick();
    for (int i = 0; i < 5; i++) begin
      idle(); expect_v(K_HLT, 8'd1); tick();
    end
    drv(EX, T0, mk(8'h01, 2'd0, 8'h99, 8'h00)); expect_v(K_HLT, 8'd1); tick();
    alu2(mk(8'h03, 2'd0, 8'h00, 8'h00));
    chk_reg(2'd0, 8'h20); chk_flags(2'b00);
    idle(); expect_v(K_HLT, 8'd1); tick();

    // Reset clears halt, registers, flags, illegal_op
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    expect_v(K_HLT, 8'd0); expect_v(K_ILL, 8'd0); expect_v(K_FLAGS, 8'd0); tick();
    for (int i = 0; i < 4; i++) chk_reg(i[1:0], 8'h00);

    // Reset between ADD T0 and T1: stale operands must not be written
    exec1(mk(8'h01, 2'd1, 8'h05, 8'h00));
    drv(EX, T0, mk(8'h03, 2'd0, 8'h01, 8'h00)); expect_v(K_END, 8'd0); tick();
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    drv(EX, T1, mk(8'h03, 2'd0, 8'h01, 8'h00)); expect_v(K_END, 8'd1); tick();
    chk_reg(2'd0, 8'h00); chk_reg(2'd1, 8'h00); chk_flags(2'b00);

    // Drain the scoreboard (bounded)
    idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      n_fail += exp_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
